// File: rtl/zeroriscy_wb_arbiter.sv
// Writeback arbiter that merges EX results and returning load data onto the
// single register file write port and tracks the one outstanding load.
module zeroriscy_wb_arbiter #(
  parameter bit RV32E      = 1'b0,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_we_i,
  input  logic [4:0]            ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  output logic                  ex_ready_o,
  input  logic                  lsu_req_i,
  input  logic [4:0]            lsu_rd_i,
  output logic                  lsu_issue_ready_o,
  input  logic                  lsu_rvalid_i,
  input  logic                  lsu_err_i,
  input  logic [DATA_WIDTH-1:0] lsu_rdata_i,
  input  logic [4:0]            dec_raddr_a_i,
  input  logic [4:0]            dec_raddr_b_i,
  input  logic [4:0]            dec_waddr_i,
  output logic                  hazard_o,
  output logic [4:0]            waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o
);

  localparam int ADDR_WIDTH = RV32E ? 4 : 5;

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, HOLD} state_t;

  state_t                state;
  logic [4:0]            pend_rd;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  sel_we;

  function automatic logic addr_eq(input logic [4:0] a, input logic [4:0] b);
    return a[ADDR_WIDTH-1:0] == b[ADDR_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pend_rd   <= '0;
      hold_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_req_i) begin
            pend_rd <= lsu_rd_i;
            state   <= WAIT_LOAD;
          end
        end
        WAIT_LOAD: begin
          // A load colliding with an EX write is parked for one cycle.
          if (lsu_rvalid_i) begin
            if (!lsu_err_i && ex_we_i) begin
              hold_data <= lsu_rdata_i;
              state     <= HOLD;
            end else begin
              state <= IDLE;
            end
          end
        end
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sel_we            = 1'b0;
    waddr_a_o         = '0;
    wdata_a_o         = '0;
    ex_ready_o        = 1'b1;
    lsu_issue_ready_o = 1'b0;
    case (state)
      IDLE: begin
        lsu_issue_ready_o = 1'b1;
        if (ex_we_i) begin
          sel_we    = 1'b1;
          waddr_a_o = ex_waddr_i;
          wdata_a_o = ex_wdata_i;
        end
      end
      WAIT_LOAD: begin
        if (ex_we_i) begin
          sel_we    = 1'b1;
          waddr_a_o = ex_waddr_i;
          wdata_a_o = ex_wdata_i;
        end else if (lsu_rvalid_i && !lsu_err_i) begin
          sel_we    = 1'b1;
          waddr_a_o = pend_rd;
          wdata_a_o = lsu_rdata_i;
        end
      end
      HOLD: begin
        ex_ready_o = 1'b0;
        sel_we     = 1'b1;
        waddr_a_o  = pend_rd;
        wdata_a_o  = hold_data;
      end
      default: ex_ready_o = 1'b0;
    endcase
  end

  // x0 is hardwired to zero: the source is consumed but nothing is written.
  assign we_a_o = sel_we && (waddr_a_o[ADDR_WIDTH-1:0] != '0);

  assign hazard_o = (state != IDLE) && (pend_rd[ADDR_WIDTH-1:0] != '0) &&
                    (addr_eq(dec_raddr_a_i, pend_rd) ||
                     addr_eq(dec_raddr_b_i, pend_rd) ||
                     addr_eq(dec_waddr_i, pend_rd));

  // A response arriving right after reset belongs to a load dropped by reset.
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    (lsu_rvalid_i && state == IDLE) |-> $past(rst));

  a_no_req_when_busy: assert property (@(posedge clk) disable iff (rst)
    lsu_req_i |-> state == IDLE);

endmodule

// File: tb/tb_zeroriscy_wb_arbiter.sv
// Directed bench for zeroriscy_wb_arbiter: expected port writes go through a
// scoreboard queue; handshake and hazard flags are checked in line.
module tb_zeroriscy_wb_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_we = 1'b0;
  logic [4:0]  ex_waddr = '0;
  logic [31:0] ex_wdata = '0;
  logic        ex_ready;
  logic        lsu_req = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic        lsu_issue_ready;
  logic        lsu_rvalid = 1'b0;
  logic        lsu_err = 1'b0;
  logic [31:0] lsu_rdata = '0;
  logic [4:0]  dec_raddr_a = '0;
  logic [4:0]  dec_raddr_b = '0;
  logic [4:0]  dec_waddr = '0;
  logic        hazard;
  logic [4:0]  waddr_a;
  logic [31:0] wdata_a;
  logic        we_a;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  zeroriscy_wb_arbiter #(.RV32E(1'b0), .DATA_WIDTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_we_i           (ex_we),
    .ex_waddr_i        (ex_waddr),
    .ex_wdata_i        (ex_wdata),
    .ex_ready_o        (ex_ready),
    .lsu_req_i         (lsu_req),
    .lsu_rd_i          (lsu_rd),
    .lsu_issue_ready_o (lsu_issue_ready),
    .lsu_rvalid_i      (lsu_rvalid),
    .lsu_err_i         (lsu_err),
    .lsu_rdata_i       (lsu_rdata),
    .dec_raddr_a_i     (dec_raddr_a),
    .dec_raddr_b_i     (dec_raddr_b),
    .dec_waddr_i       (dec_waddr),
    .hazard_o          (hazard),
    .waddr_a_o         (waddr_a),
    .wdata_a_o         (wdata_a),
    .we_a_o            (we_a)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_data,
                               input logic l_req, input logic [4:0] l_rd,
                               input logic l_rv, input logic l_err, input logic [31:0] l_data);
    ex_we      = e_we;
    ex_waddr   = e_addr;
    ex_wdata   = e_data;
    lsu_req    = l_req;
    lsu_rd     = l_rd;
    lsu_rvalid = l_rv;
    lsu_err    = l_err;
    lsu_rdata  = l_data;
  endtask

  task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every register file write must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && we_a) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write: got addr %0d data 0x%0h expected no write", waddr_a, wdata_a);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          checkOutput("write_addr", {27'd0, waddr_a}, {27'd0, w.addr});
          checkOutput("write_data", wdata_a, w.data);
        end
      end
    end
  end

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_we", {31'd0, we_a}, 0);
    checkOutput("reset_waddr", {27'd0, waddr_a}, 0);
    checkOutput("reset_wdata", wdata_a, 0);
    checkOutput("reset_ex_ready", {31'd0, ex_ready}, 1);
    checkOutput("reset_issue_ready", {31'd0, lsu_issue_ready}, 1);
    checkOutput("reset_hazard", {31'd0, hazard}, 0);
    nextCycle();
    rst = 1'b0;

    // EX writes, including the suppressed x0 write
    applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    expectWrite(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("ex_ready_x5", {31'd0, ex_ready}, 1);
    nextCycle();
    applyStimulus(1, 5'd0, 32'h1234, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("x0_we", {31'd0, we_a}, 0);
    checkOutput("ex_ready_x0", {31'd0, ex_ready}, 1);
    nextCycle();

    // Load to x7 with a three-cycle response
    applyStimulus(0, 0, 0, 1, 5'd7, 0, 0, 0);
    @(negedge clk);
    checkOutput("issue_ready_idle", {31'd0, lsu_issue_ready}, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    dec_raddr_a = 5'd7;
    @(negedge clk);
    checkOutput("hazard_x7", {31'd0, hazard}, 1);
    checkOutput("issue_ready_wait", {31'd0, lsu_issue_ready}, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("hazard_x7_wait", {31'd0, hazard}, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'hCAFEF00D);
    expectWrite(5'd7, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("hazard_x7_data", {31'd0, hazard}, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("hazard_x7_clear", {31'd0, hazard}, 0);
    checkOutput("issue_ready_after", {31'd0, lsu_issue_ready}, 1);
    nextCycle();
    dec_raddr_a = 5'd0;

    // Load to x9 colliding with EX write of x3; EX stalls in the hold cycle
    applyStimulus(0, 0, 0, 1, 5'd9, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 5'd3, 32'h22, 0, 0, 1, 0, 32'h11);
    expectWrite(5'd3, 32'h22);
    @(negedge clk);
    checkOutput("ex_ready_collide", {31'd0, ex_ready}, 1);
    nextCycle();
    applyStimulus(1, 5'd10, 32'h33, 0, 0, 0, 0, 0);
    dec_waddr = 5'd9;
    expectWrite(5'd9, 32'h11);
    @(negedge clk);
    checkOutput("ex_ready_hold", {31'd0, ex_ready}, 0);
    checkOutput("issue_ready_hold", {31'd0, lsu_issue_ready}, 0);
    checkOutput("hazard_waw_hold", {31'd0, hazard}, 1);
    nextCycle();
    expectWrite(5'd10, 32'h33);
    @(negedge clk);
    checkOutput("ex_ready_after_hold", {31'd0, ex_ready}, 1);
    checkOutput("hazard_after_hold", {31'd0, hazard}, 0);
    nextCycle();
    dec_waddr = 5'd0;

    // Load to x4 returning a bus error alongside an EX write of x6
    applyStimulus(0, 0, 0, 1, 5'd4, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 5'd6, 32'h66, 0, 0, 1, 1, 32'hBAD);
    dec_raddr_b = 5'd4;
    expectWrite(5'd6, 32'h66);
    @(negedge clk);
    checkOutput("hazard_err_cycle", {31'd0, hazard}, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("hazard_err_clear", {31'd0, hazard}, 0);
    nextCycle();
    dec_raddr_b = 5'd0;

    // Load to x8 dropped by reset; the late response must not write
    applyStimulus(0, 0, 0, 1, 5'd8, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    dec_raddr_a = 5'd8;
    @(negedge clk);
    checkOutput("hazard_x8", {31'd0, hazard}, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("hazard_async_reset", {31'd0, hazard}, 0);
    checkOutput("issue_ready_async_reset", {31'd0, lsu_issue_ready}, 1);
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h77);
    @(negedge clk);
    checkOutput("late_rvalid_we", {31'd0, we_a}, 0);
    checkOutput("late_rvalid_hazard", {31'd0, hazard}, 0);
    nextCycle();
    applyStimulus(1, 5'd1, 32'hA5, 0, 0, 0, 0, 0);
    dec_raddr_a = 5'd0;
    expectWrite(5'd1, 32'hA5);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) nextCycle();

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zeroriscy_wb_arbiter.md
Name: zeroriscy_wb_arbiter

Overview:
- Writeback stage directly upstream of the latch-based register file write port (waddr_a/wdata_a/we_a).
- Merges two write sources onto the single write port:
  - single-cycle EX results (ALU/CSR/mult);
  - returning LSU load data.
- Tracks the one outstanding load's destination register and raises a decode hazard until that data has been written.
- Resolves EX/load write collisions with a one-entry hold buffer and a one-cycle EX back-pressure bubble.

Parameters:
- RV32E, 0, 1 = 16-register file; register addresses compared on 4 bits (ADDR_WIDTH=4), else 5 bits.
- DATA_WIDTH, 32, write data width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- ex_we_i  input  1  EX result write request
- ex_waddr_i  input  5  EX destination register
- ex_wdata_i  input  DATA_WIDTH  EX result
- ex_ready_o  output  1  EX write accepted this cycle when high
- lsu_req_i  input  1  load issued this cycle (one-cycle pulse)
- lsu_rd_i  input  5  load destination register, valid with lsu_req_i
- lsu_issue_ready_o  output  1  new load may issue
- lsu_rvalid_i  input  1  load response valid
- lsu_err_i  input  1  load bus error, qualifies lsu_rvalid_i
- lsu_rdata_i  input  DATA_WIDTH  load data
- dec_raddr_a_i  input  5  decode operand A address
- dec_raddr_b_i  input  5  decode operand B address
- dec_waddr_i  input  5  decode destination address
- hazard_o  output  1  decode must stall
- waddr_a_o  output  5  register file write address
- wdata_a_o  output  DATA_WIDTH  register file write data
- we_a_o  output  1  register file write enable

Behaviour:
- State register: IDLE, WAIT_LOAD, HOLD.
- Internal registers: pend_rd[4:0], hold_data[DATA_WIDTH-1:0].
- Reset values: state=IDLE, pend_rd=0, hold_data=0.
- Outputs are combinational from state and inputs. In IDLE with no inputs: we_a_o=0, waddr_a_o=0, wdata_a_o=0, ex_ready_o=1, lsu_issue_ready_o=1, hazard_o=0.
- Address compares use the low ADDR_WIDTH bits only.
- A write to x0 is never issued: we_a_o is forced to 0 when the selected address is 0. The source is still consumed.
- IDLE:
  - ex_ready_o=1; ex_we_i drives the port (we/waddr/wdata = ex_*).
  - lsu_req_i: capture pend_rd=lsu_rd_i and go to WAIT_LOAD. EX writes in the same cycle are unaffected.
  - lsu_rvalid_i in IDLE is ignored and flagged by an assertion.
- WAIT_LOAD:
  - lsu_issue_ready_o=0; ex_ready_o=1.
  - rvalid & err: no load write; go to IDLE. EX writes normally.
  - rvalid & !err & !ex_we_i: port = {pend_rd, lsu_rdata_i}; go to IDLE.
  - rvalid & !err & ex_we_i: EX wins the port; capture hold_data=lsu_rdata_i; go to HOLD.
  - No rvalid: stay. The wait is unbounded.
- HOLD:
  - ex_ready_o=0 and lsu_issue_ready_o=0.
  - Port = {pend_rd, hold_data}; go to IDLE.
  - ex_we_i is not accepted this cycle; EX holds its request.
- lsu_req_i outside IDLE is a protocol violation: ignored and asserted against.
- Hazard:
  - hazard_o=1 when state!=IDLE, pend_rd!=0, and any of dec_raddr_a_i, dec_raddr_b_i or dec_waddr_i equals pend_rd.
  - This includes the cycle in which the load data is presented on the port.
  - The dec_waddr_i compare prevents a younger EX write being overwritten by the older load (WAW).
- Latency:
  - EX write reaches the port in the same cycle it is accepted.
  - Load write reaches the port in the rvalid cycle, or rvalid+1 on a collision.
  - The register file adds its own write latency.
- Reset asserted mid-operation (any state): immediately returns to IDLE. The pending load is dropped, hazard_o=0 and we_a_o=0. A late rvalid after reset is ignored.

Test Plan:
- Reset, then EX writes x5=0xDEADBEEF -> same cycle we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF, ex_ready_o=1.
- EX writes x0=0x1234 -> we_a_o=0 and ex_ready_o=1.
- Load to x7 issued, then dec_raddr_a=7 -> hazard_o=1 and lsu_issue_ready_o=0. Three cycles later rvalid with 0xCAFEF00D -> port {7,0xCAFEF00D}, we=1. Next cycle hazard_o=0 and state IDLE.
- Load to x9; rvalid with 0x11 in the same cycle as an EX write of x3=0x22 -> that cycle port {3,0x22}. Next cycle port {9,0x11}, ex_ready_o=0. Cycle after, ex_ready_o=1.
- Load to x4 returns rvalid with lsu_err_i=1 -> no write to x4, hazard clears next cycle. A same-cycle EX write of x6 proceeds normally.
- Load to x8 outstanding, rst pulsed -> state IDLE, hazard_o=0. A later rvalid produces no write.
